// File: rtl/scale_pipe.sv
// Pipelined display-to-source coordinate scaler with per-axis power-of-two upscale,
// crop origin, and frame-synchronous double-buffered config. Option macro: SCALE_ADDR_EN.
module scale_pipe #(
    parameter int H_W        = 11,
    parameter int V_W        = 10,
    parameter int SRC_WIDTH  = 240,
    parameter int SRC_HEIGHT = 320,
    parameter int MAX_SHIFT  = 2,
    parameter int ADDR_W     = $clog2(SRC_WIDTH*SRC_HEIGHT)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [H_W-1:0]    hcount_in,
    input  logic [V_W-1:0]    vcount_in,
    input  logic              pix_valid_in,
    input  logic [1:0]        h_shift_in,
    input  logic [1:0]        v_shift_in,
    input  logic [H_W-1:0]    h_off_in,
    input  logic [V_W-1:0]    v_off_in,
    input  logic              cfg_valid_in,
    output logic              cfg_ready_out,
    output logic [H_W-1:0]    scaled_hcount_out,
    output logic [V_W-1:0]    scaled_vcount_out,
    output logic              valid_addr_out
`ifdef SCALE_ADDR_EN
    ,
    output logic [ADDR_W-1:0] addr_out
`endif
);

    // state   | meaning
    // IDLE    | no config waiting, ready for a new offer
    // PENDING | shadow holds a config that lands on the next frame start
    typedef enum logic {IDLE, PENDING} state_t;

    localparam logic [1:0]     MAX_S = 2'(MAX_SHIFT);
    localparam logic [H_W-1:0] SRC_W = H_W'(SRC_WIDTH);
    localparam logic [V_W-1:0] SRC_H = V_W'(SRC_HEIGHT);

    state_t state, state_nx;
    logic   ready_nx;
    logic   frame_start, handshake, apply;

    logic [1:0]     h_shift, v_shift, sh_h_shift, sh_v_shift;
    logic [H_W-1:0] h_off, sh_h_off;
    logic [V_W-1:0] v_off, sh_v_off;

    assign frame_start = (hcount_in == '0) && (vcount_in == '0);
    assign handshake   = cfg_valid_in && cfg_ready_out;
    assign apply       = (state == PENDING) && frame_start;

    always_ff @(posedge clk_in) begin
        if (!rst_in) state <= IDLE;
        else         state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (handshake)   state_nx = PENDING;
            PENDING: if (frame_start) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ready_nx = (state_nx == IDLE);
    end

    // Ready is registered so it stays low through reset and rises one edge after release.
    always_ff @(posedge clk_in) begin
        if (!rst_in) cfg_ready_out <= 1'b0;
        else         cfg_ready_out <= ready_nx;
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            h_shift    <= '0;
            v_shift    <= '0;
            h_off      <= '0;
            v_off      <= '0;
            sh_h_shift <= '0;
            sh_v_shift <= '0;
            sh_h_off   <= '0;
            sh_v_off   <= '0;
        end else begin
            if (handshake) begin
                sh_h_shift <= (h_shift_in > MAX_S) ? MAX_S : h_shift_in;
                sh_v_shift <= (v_shift_in > MAX_S) ? MAX_S : v_shift_in;
                sh_h_off   <= h_off_in;
                sh_v_off   <= v_off_in;
            end
            if (apply) begin
                h_shift <= sh_h_shift;
                v_shift <= sh_v_shift;
                h_off   <= sh_h_off;
                v_off   <= sh_v_off;
            end
        end
    end

    // Stage 1: the frame-start pixel that applies the shadow is already processed with it.
    logic [1:0]     cur_hs, cur_vs;
    logic [H_W-1:0] cur_ho;
    logic [V_W-1:0] cur_vo;
    logic [H_W:0]   dh;
    logic [V_W:0]   dv;

    assign cur_hs = apply ? sh_h_shift : h_shift;
    assign cur_vs = apply ? sh_v_shift : v_shift;
    assign cur_ho = apply ? sh_h_off   : h_off;
    assign cur_vo = apply ? sh_v_off   : v_off;
    assign dh     = {1'b0, hcount_in} - {1'b0, cur_ho};
    assign dv     = {1'b0, vcount_in} - {1'b0, cur_vo};

    logic [H_W-1:0] s1_dh;
    logic [V_W-1:0] s1_dv;
    logic           s1_bh, s1_bv, s1_pv;
    logic [1:0]     s1_hs, s1_vs;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            s1_dh <= '0;
            s1_dv <= '0;
            s1_bh <= 1'b0;
            s1_bv <= 1'b0;
            s1_pv <= 1'b0;
            s1_hs <= '0;
            s1_vs <= '0;
        end else begin
            s1_dh <= dh[H_W-1:0];
            s1_dv <= dv[V_W-1:0];
            s1_bh <= dh[H_W];
            s1_bv <= dv[V_W];
            s1_pv <= pix_valid_in;
            s1_hs <= cur_hs;
            s1_vs <= cur_vs;
        end
    end

    // Stage 2: scale down and bound-check against the source buffer.
    logic [H_W-1:0] sx;
    logic [V_W-1:0] sy;
    logic           valid2;

    assign sx     = s1_dh >> s1_hs;
    assign sy     = s1_dv >> s1_vs;
    assign valid2 = s1_pv && !s1_bh && !s1_bv && (sx < SRC_W) && (sy < SRC_H);

`ifdef SCALE_ADDR_EN
    logic [H_W-1:0]    s2_x;
    logic [V_W-1:0]    s2_y;
    logic              s2_v;
    logic [ADDR_W-1:0] addr_full;

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            s2_x <= '0;
            s2_y <= '0;
            s2_v <= 1'b0;
        end else begin
            s2_x <= valid2 ? sx : '0;
            s2_y <= valid2 ? sy : '0;
            s2_v <= valid2;
        end
    end

    assign addr_full = ADDR_W'(s2_y) * ADDR_W'(SRC_WIDTH) + ADDR_W'(s2_x);

    // Stage 3: linear address; coordinates and valid are delayed to stay aligned.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            scaled_hcount_out <= '0;
            scaled_vcount_out <= '0;
            valid_addr_out    <= 1'b0;
            addr_out          <= '0;
        end else begin
            scaled_hcount_out <= s2_x;
            scaled_vcount_out <= s2_y;
            valid_addr_out    <= s2_v;
            addr_out          <= s2_v ? addr_full : '0;
        end
    end
`else
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            scaled_hcount_out <= '0;
            scaled_vcount_out <= '0;
            valid_addr_out    <= 1'b0;
        end else begin
            scaled_hcount_out <= valid2 ? sx : '0;
            scaled_vcount_out <= valid2 ? sy : '0;
            valid_addr_out    <= valid2;
        end
    end
`endif

endmodule

// File: doc/scale_pipe.md
# scale_pipe

Parametrised, pipelined pixel-coordinate scaler for the camera-to-frame-buffer read path. It maps raw display counters (hcount/vcount) to source-buffer coordinates with independent per-axis power-of-two upscaling and a programmable crop origin. Configuration is double-buffered: a new setting is accepted through a valid/ready handshake and applied only at a frame boundary. It sits between the video timing generator and the frame-buffer BRAM read port.

## Interface
Parameters:
- H_W, 11, hcount width
- V_W, 10, vcount width
- SRC_WIDTH, 240, source buffer width in pixels
- SRC_HEIGHT, 320, source buffer height in pixels
- MAX_SHIFT, 2, largest accepted log2 scale per axis
- ADDR_W, $clog2(SRC_WIDTH*SRC_HEIGHT), linear address width

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  synchronous, active-low reset
- hcount_in  input  H_W  display horizontal counter
- vcount_in  input  V_W  display vertical counter
- pix_valid_in  input  1  counters are in the active area
- h_shift_in  input  2  requested horizontal log2 scale
- v_shift_in  input  2  requested vertical log2 scale
- h_off_in  input  H_W  crop origin, horizontal, in display pixels
- v_off_in  input  V_W  crop origin, vertical, in display pixels
- cfg_valid_in  input  1  config offer
- cfg_ready_out  output  1  config can be accepted
- scaled_hcount_out  output  H_W  source x
- scaled_vcount_out  output  V_W  source y
- valid_addr_out  output  1  source coordinate is inside the buffer
- addr_out  output  ADDR_W  linear address (SCALE_ADDR_EN only)

## Operation
- Active config registers: h_shift, v_shift, h_off, v_off. Reset value is 0 for all (scale 1, no crop).
- Config FSM:
  - IDLE: cfg_ready_out=1. When cfg_valid_in && cfg_ready_out, capture the inputs into the shadow registers and go to PENDING.
  - PENDING: cfg_ready_out=0. On the first frame-start cycle strictly after the acceptance cycle, copy shadow to active and return to IDLE.
  - Frame start means hcount_in==0 && vcount_in==0.
- Shifts greater than MAX_SHIFT are clamped to MAX_SHIFT at capture.
- The pixel presented on the applying frame-start cycle is already processed with the new config, so the pipeline stage-1 mux selects the shadow registers on that cycle.
- Stage 1:
  - dh = {1'b0,hcount_in} - {1'b0,h_off}, H_W+1 bits; dv is computed the same way.
  - A borrow (MSB set) marks the coordinate out of window.
  - The stage also registers pix_valid_in and the shifts it used.
- Stage 2:
  - sx = dh[H_W-1:0] >> h_shift; sy = dv[V_W-1:0] >> v_shift.
  - valid = pix_valid && !borrow_h && !borrow_v && sx<SRC_WIDTH && sy<SRC_HEIGHT.
  - The outputs register sx and sy when valid. When not valid, both coordinate outputs are 0.
- With SCALE_ADDR_EN, stage 3 computes addr_out = sy*SRC_WIDTH + sx, truncated to ADDR_W bits. It is 0 when not valid.

## Timing
- Latency: 2 cycles from inputs to outputs, or 3 cycles with SCALE_ADDR_EN. All outputs stay mutually aligned; the coordinate and valid outputs are delayed one extra stage when the address stage is present.
- Throughput: one pixel per cycle, with no stalls.
- Reset (rst_in=0 at a clock edge):
  - All outputs and pipeline registers go to 0, and the FSM goes to IDLE.
  - cfg_ready_out is 0 during reset and 1 on the first cycle after reset is released.
  - A pending config is discarded, and the active config returns to 0.
- A handshake in the same cycle as a frame start does not apply on that frame; it applies at the next frame start.
- cfg_valid_in while PENDING is ignored: there is no overwrite and no queueing.
- Coordinates wrap only through the explicit truncation above. Any overflow beyond the source bounds deasserts valid_addr_out.

## Configuration
- SCALE_ADDR_EN defined:
  - The addr_out port and stage 3 are present.
  - Latency is 3 cycles.
- SCALE_ADDR_EN undefined:
  - addr_out is absent.
  - Latency is 2 cycles.
  - The block uses no multiplier.

## Test plan
- Reset, then sweep h=0..479, v=0..639 with default config: scaled equals input, and valid is 1 exactly for h<240 && v<320. Coordinate outputs lag the inputs by 2 cycles.
- Offer h_shift=1, v_shift=1 mid-frame: ready drops the next cycle and the config applies at (0,0). Input h=479, v=639 must then give scaled (239,319) with valid=1.
- Apply h_off=100, v_off=50, shift=0. Input (99,60) must give valid=0 (borrow). Input (100,50) must give (0,0) with valid=1.
- Offer h_shift=3: it is clamped to 2, so input h=956 gives scaled_h=239.
- Assert the handshake on the frame-start cycle: it must not apply on that frame, and must apply at the next (0,0). Assert rst_in=0 while PENDING: the config is discarded, shifts are back to 0, and ready=1 after release.
- With SCALE_ADDR_EN, input (5,2) at scale 1 must give addr_out=485 after 3 cycles. An out-of-window pixel must give addr_out=0 and valid=0.
